// File: rtl/strip_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : strip_scan_ctrl
// Purpose  : Scans a column-per-word frame RAM for the leftmost inked column,
//            then fetches the test strip OFFSET columns to its right (clamped
//            to the last column). The result goes out on a valid/ready
//            handshake.
// Ports    : clk, rst_n        - clock, async active-low reset
//            start_i           - begin a scan (sampled only when idle)
//            busy_o            - controller is not idle
//            mem_rd_en_o       - frame RAM read enable
//            mem_addr_o        - frame RAM column address
//            mem_rdata_i       - column word, valid the cycle after a read
//            strip_o           - selected column word
//            strip_valid_o     - result outputs are valid
//            strip_ready_i     - consumer accepts the result
//            found_o           - an inked column existed
//            left_col_o        - index of the leftmost inked column
//            strip_col_o       - index of the column returned in strip_o
// Revision : 1.0 - initial release
// ============================================================================
module strip_scan_ctrl #(
  parameter int ROWS   = 300,
  parameter int COLS   = 200,
  parameter int OFFSET = 30,
  parameter int AW     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            busy_o,
  output logic            mem_rd_en_o,
  output logic [AW-1:0]   mem_addr_o,
  input  logic [ROWS-1:0] mem_rdata_i,
  output logic [ROWS-1:0] strip_o,
  output logic            strip_valid_o,
  input  logic            strip_ready_i,
  output logic            found_o,
  output logic [AW-1:0]   left_col_o,
  output logic [AW-1:0]   strip_col_o
);

  localparam logic [AW:0]   c_COLS_EXT   = (AW+1)'(COLS);
  localparam logic [AW:0]   c_OFFSET_EXT = (AW+1)'(OFFSET);
  localparam logic [AW-1:0] c_LAST_COL   = AW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic            mem_rd_en_q;
  logic [AW-1:0]   mem_addr_q;
  logic [ROWS-1:0] strip_q;
  logic            strip_valid_q;
  logic            found_q;
  logic [AW-1:0]   left_col_q;
  logic [AW-1:0]   strip_col_q;

  // Next column to issue; one bit wider so it can reach COLS itself.
  logic [AW:0]     issue_addr_q;
  // Address and validity of the word currently on mem_rdata_i.
  logic [AW-1:0]   chk_addr_q;
  logic            chk_valid_q;

  logic [AW:0]     strip_sum_d;
  logic [AW-1:0]   strip_col_d;
  logic            hit_d;
  logic            last_chk_d;

  // Strip column: sum at AW+1 bits so it cannot wrap before the clamp.
  always_comb begin
    strip_sum_d = {1'b0, chk_addr_q} + c_OFFSET_EXT;
    if (strip_sum_d > {1'b0, c_LAST_COL}) begin
      strip_col_d = c_LAST_COL;
    end else begin
      strip_col_d = strip_sum_d[AW-1:0];
    end
  end

  assign hit_d      = chk_valid_q && (|mem_rdata_i);
  assign last_chk_d = chk_valid_q && (chk_addr_q == c_LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      strip_q       <= '0;
      strip_valid_q <= 1'b0;
      found_q       <= 1'b0;
      left_col_q    <= '0;
      strip_col_q   <= '0;
      issue_addr_q  <= '0;
      chk_addr_q    <= '0;
      chk_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // Read enable and address are registered, so column 0 is issued
            // here and the issue pointer already points at column 1.
            state_q      <= S_SCAN;
            busy_q       <= 1'b1;
            mem_rd_en_q  <= 1'b1;
            mem_addr_q   <= '0;
            issue_addr_q <= (AW+1)'(1);
            chk_valid_q  <= 1'b0;
          end
        end

        S_SCAN: begin
          // Track which address the RAM will present next cycle.
          chk_valid_q <= mem_rd_en_q;
          chk_addr_q  <= mem_addr_q;

          if (issue_addr_q < c_COLS_EXT) begin
            mem_rd_en_q  <= 1'b1;
            mem_addr_q   <= issue_addr_q[AW-1:0];
            issue_addr_q <= issue_addr_q + (AW+1)'(1);
          end else begin
            mem_rd_en_q <= 1'b0;
          end

          if (hit_d) begin
            // The read for chk_addr+1 issued this cycle is speculative; the
            // FETCH read replaces it and its data is never captured.
            found_q     <= 1'b1;
            left_col_q  <= chk_addr_q;
            strip_col_q <= strip_col_d;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= strip_col_d;
            state_q     <= S_FETCH;
          end else if (last_chk_d) begin
            found_q       <= 1'b0;
            left_col_q    <= '0;
            strip_col_q   <= '0;
            strip_q       <= '0;
            mem_rd_en_q   <= 1'b0;
            strip_valid_q <= 1'b1;
            state_q       <= S_OUT;
          end
        end

        S_FETCH: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= S_WAIT;
        end

        S_WAIT: begin
          strip_q       <= mem_rdata_i;
          strip_valid_q <= 1'b1;
          state_q       <= S_OUT;
        end

        S_OUT: begin
          if (strip_ready_i) begin
            strip_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          mem_rd_en_q   <= 1'b0;
          strip_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign strip_o       = strip_q;
  assign strip_valid_o = strip_valid_q;
  assign found_o       = found_q;
  assign left_col_o    = left_col_q;
  assign strip_col_o   = strip_col_q;

endmodule
`default_nettype wire

// File: tb/tb_strip_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_strip_scan_ctrl
// Purpose  : Self-checking bench for strip_scan_ctrl. A frame RAM model
//            holds random images; a reference model derives each expected
//            result, which a monitor compares when strip_valid_o is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_strip_scan_ctrl;

  localparam int ROWS   = 300;
  localparam int COLS   = 200;
  localparam int OFFSET = 30;
  localparam int AW     = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            strip_ready = 1'b1;
  logic [ROWS-1:0] mem_rdata = '0;
  logic            busy, mem_rd_en, strip_valid, found;
  logic [AW-1:0]   mem_addr, left_col, strip_col;
  logic [ROWS-1:0] strip;

  strip_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .OFFSET(OFFSET), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .busy_o        (busy),
    .mem_rd_en_o   (mem_rd_en),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .strip_o       (strip),
    .strip_valid_o (strip_valid),
    .strip_ready_i (strip_ready),
    .found_o       (found),
    .left_col_o    (left_col),
    .strip_col_o   (strip_col)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM: synchronous read, data valid the cycle after the enable.
  logic [ROWS-1:0] img [COLS];
  always @(posedge clk) begin
    if (mem_rd_en && (int'(mem_addr) < COLS)) mem_rdata <= img[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [ROWS-1:0] act,
                     input logic [ROWS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int              cyc;      // cycle strip_valid must first be high
    int              c0;       // cycle start was sampled
    bit              found;
    int              left;
    int              scol;
    logic [ROWS-1:0] strip;
    int              rd_cnt;   // read-enable cycles from start to result
    int              addr_sum; // sum of all addresses read
  } exp_t;

  exp_t exp_q[$];

  // Reference model: leftmost nonzero column and clamped strip.
  function automatic exp_t model(input int c0);
    exp_t e;
    int   l = -1;
    int   last;
    for (int k = 0; k < COLS; k++) begin
      if (img[k] != '0) begin
        l = k;
        break;
      end
    end
    e.c0 = c0;
    if (l < 0) begin
      e.found    = 1'b0;
      e.left     = 0;
      e.scol     = 0;
      e.strip    = '0;
      e.cyc      = c0 + COLS + 2;
      e.rd_cnt   = COLS;
      e.addr_sum = COLS * (COLS - 1) / 2;
    end else begin
      e.found    = 1'b1;
      e.left     = l;
      e.scol     = (l + OFFSET > COLS - 1) ? COLS - 1 : l + OFFSET;
      e.strip    = img[e.scol];
      e.cyc      = c0 + l + 5;
      last       = (l + 1 < COLS) ? l + 1 : COLS - 1;
      e.rd_cnt   = last + 2;
      e.addr_sum = last * (last + 1) / 2 + e.scol;
    end
    return e;
  endfunction

  function automatic logic [ROWS-1:0] rand_word();
    logic [ROWS-1:0] w = '0;
    for (int i = 0; i < 10; i++) w = {w[ROWS-33:0], 32'($urandom())};
    return w;
  endfunction

  function automatic logic [ROWS-1:0] rand_sparse();
    logic [ROWS-1:0] w = '0;
    int              b;
    case ($urandom_range(0, 3))
      0: w = '0;
      1: begin
        b = int'($urandom_range(0, ROWS - 1));
        w[b] = 1'b1;
      end
      2: w = rand_word() & rand_word() & rand_word();
      default: w = rand_word();
    endcase
    return w;
  endfunction

  // Leftmost inked column at l; l == COLS gives an empty image.
  task automatic fill_image(input int l);
    logic [ROWS-1:0] w;
    int              b;
    for (int k = 0; k < COLS; k++) begin
      if (k < l) begin
        img[k] = '0;
      end else if (k == l) begin
        w = rand_sparse();
        if (w == '0) begin
          b = int'($urandom_range(0, ROWS - 1));
          w[b] = 1'b1;
        end
        img[k] = w;
      end else begin
        img[k] = rand_sparse();
      end
    end
  endtask

  // Monitor: counts reads per scan and checks each OUT cycle.
  int   rd_cnt = 0;
  int   addr_sum = 0;
  int   first_rd_cyc = -1;
  int   first_rd_addr = -1;
  bit   prev_valid = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (start && !busy) begin
        rd_cnt        = 0;
        addr_sum      = 0;
        first_rd_cyc  = -1;
        first_rd_addr = -1;
      end
      if (mem_rd_en) begin
        chk("addr_range", ROWS'(int'(mem_addr) < COLS), ROWS'(1'b1));
        if (first_rd_cyc < 0) begin
          first_rd_cyc  = cyc;
          first_rd_addr = int'(mem_addr);
        end
        rd_cnt++;
        addr_sum += int'(mem_addr);
      end
      if (strip_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got strip_valid=1 expected no result");
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            chk("valid_cycle", ROWS'(cyc), ROWS'(cur.cyc));
            chk("rd_count", ROWS'(rd_cnt), ROWS'(cur.rd_cnt));
            chk("addr_sum", ROWS'(addr_sum), ROWS'(cur.addr_sum));
            chk("first_rd_cycle", ROWS'(first_rd_cyc), ROWS'(cur.c0 + 1));
            chk("first_rd_addr", ROWS'(first_rd_addr), ROWS'(0));
          end
        end
        if (have_cur) begin
          chk("found", ROWS'(found), ROWS'(cur.found));
          chk("left_col", ROWS'(left_col), ROWS'(cur.left));
          chk("strip_col", ROWS'(strip_col), ROWS'(cur.scol));
          chk("strip", strip, cur.strip);
          chk("busy_in_out", ROWS'(busy), ROWS'(1'b1));
          chk("rd_en_in_out", ROWS'(mem_rd_en), ROWS'(1'b0));
        end
      end
      prev_valid = strip_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, ROWS'(busy), ROWS'(1'b0));
    chk({tag, "_rd_en"}, ROWS'(mem_rd_en), ROWS'(1'b0));
    chk({tag, "_addr"}, ROWS'(mem_addr), ROWS'(0));
    chk({tag, "_valid"}, ROWS'(strip_valid), ROWS'(1'b0));
    chk({tag, "_found"}, ROWS'(found), ROWS'(1'b0));
    chk({tag, "_left"}, ROWS'(left_col), ROWS'(0));
    chk({tag, "_scol"}, ROWS'(strip_col), ROWS'(0));
    chk({tag, "_strip"}, strip, ROWS'(0));
  endtask

  // One complete scan; bp > 0 holds strip_ready low for bp OUT cycles and
  // pulses start during OUT and in the handshake cycle.
  task automatic run_scan(input int bp);
    exp_t e;
    bit   seen = 1'b0;
    @(posedge clk); #1;
    e = model(cyc);
    exp_q.push_back(e);
    start       = 1'b1;
    strip_ready = (bp == 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_cycle1", ROWS'(busy), ROWS'(1'b1));
    for (int i = 0; i < COLS + 20; i++) begin
      if (strip_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got no strip_valid expected one by cycle %0d", e.cyc);
      exp_q.delete();
      strip_ready = 1'b1;
      return;
    end
    if (bp > 0) begin
      for (int i = 1; i < bp; i++) begin
        @(posedge clk); #1;
        start = (i == 2);
      end
      @(posedge clk); #1;
      strip_ready = 1'b1;
      start       = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_hs", ROWS'(busy), ROWS'(1'b0));
    chk("valid_after_hs", ROWS'(strip_valid), ROWS'(1'b0));
    chk("rd_en_after_hs", ROWS'(mem_rd_en), ROWS'(1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   l;
    int   c0;
    exp_t e;
    int   edges [3];
    edges = '{COLS - OFFSET - 1, COLS - OFFSET, COLS - 1};
    for (int k = 0; k < COLS; k++) img[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle");

    // Leftmost column 5, column 35 = 0xA5.
    fill_image(5);
    img[35] = ROWS'(8'hA5);
    run_scan(0);

    // Empty image.
    fill_image(COLS);
    run_scan(0);

    // Clamped strip.
    fill_image(180);
    run_scan(0);

    // Column 0 inked, speculative read of column 1 must not leak.
    fill_image(0);
    img[1]  = rand_word() | ROWS'(1);
    img[30] = '1;
    run_scan(0);

    // Backpressure.
    fill_image(int'($urandom_range(0, COLS - 1)));
    run_scan(7);

    // Clamp boundaries.
    foreach (edges[i]) begin
      fill_image(edges[i]);
      run_scan(int'($urandom_range(0, 4)));
    end

    // Random images.
    for (int n = 0; n < 10; n++) begin
      l = ($urandom_range(0, 5) == 0) ? COLS : int'($urandom_range(0, COLS - 1));
      fill_image(l);
      run_scan(int'($urandom_range(0, 4)));
    end

    // Reset in cycle 50 of a scan, after a result left found/left nonzero.
    fill_image(10);
    run_scan(0);
    fill_image(COLS);
    @(posedge clk); #1;
    c0 = cyc;
    e  = model(c0);
    exp_q.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 50) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_addr", ROWS'(mem_addr), ROWS'(49));
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_image(int'($urandom_range(0, 60)));
    run_scan(0);

    repeat (3) @(posedge clk);
    chk("queue_drained", ROWS'(exp_q.size()), ROWS'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/strip_scan_ctrl.md
# strip_scan_ctrl

Sequential controller that locates the leftmost inked column of a binarized digit image and fetches the vertical test strip a fixed offset to its right. The image is held column-per-word in a single-port synchronous frame RAM. This block owns that RAM's read port and scans it one column per cycle. It delivers the selected column word, plus its indices, to the feature/classifier stage over a valid/ready handshake.

## Interface
- `ROWS`, 300, bits per column word (pixel rows)
- `COLS`, 200, number of columns (RAM depth)
- `OFFSET`, 30, column distance from leftmost inked column to test strip
- `AW`, 8, column address width, must satisfy 2^AW ≥ COLS
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin a scan; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `mem_rd_en` out 1: frame RAM read enable
- `mem_addr` out AW: frame RAM column address
- `mem_rdata` in ROWS: column word, valid the cycle after `mem_rd_en`
- `strip` out ROWS: selected column word
- `strip_valid` out 1: `strip`, `found`, `left_col` and `strip_col` are valid
- `strip_ready` in 1: consumer accepts the result
- `found` out 1: an inked column existed
- `left_col` out AW: index of leftmost nonzero column
- `strip_col` out AW: index of the column returned in `strip`

## Operation
- FSM states: IDLE, SCAN, FETCH, WAIT, OUT.
- IDLE: `start`=1 moves to SCAN and clears `issue_addr` to 0.
- SCAN, issue side:
  - `mem_rd_en`=1 with `mem_addr`=`issue_addr` while `issue_addr` < COLS.
  - `issue_addr` increments each cycle.
  - A delayed copy `chk_addr` tracks the address whose data is on `mem_rdata`.
- SCAN, check side: a column counts as inked when `|mem_rdata`=1 and a read was issued the previous cycle.
  - On the first inked column, `left_col`←`chk_addr` and `found`←1.
  - `strip_col`←min(`chk_addr`+OFFSET, COLS-1). Compute the sum at AW+1 bits before the clamp.
  - The FSM then moves to FETCH.
  - The read already issued for `chk_addr`+1 in the hit cycle is speculative and its data is discarded.
- SCAN with no inked column: after the check of column COLS-1, `found`←0, `left_col`←0, `strip_col`←0 and `strip`←0, and the FSM moves to OUT.
- FETCH: `mem_rd_en`=1, `mem_addr`=`strip_col`. Next state is WAIT.
- WAIT: `strip`←`mem_rdata`. Next state is OUT.
- OUT:
  - `strip_valid`=1.
  - All result outputs hold stable until `strip_ready`=1.
  - On the handshake the FSM returns to IDLE.
- `start` is ignored whenever the FSM is not in IDLE, including the handshake cycle.
- `mem_rd_en`=0 in IDLE, WAIT and OUT. `mem_addr` holds its last value when not reading.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `mem_rd_en`, `strip_valid` and `found` = 0.
  - `mem_addr`, `left_col` and `strip_col` = 0.
  - `strip` = 0.
- Reset mid-operation returns to IDLE immediately and asynchronously; no result is produced.
- Cycle numbering: the cycle in which `start` is sampled high in IDLE is cycle 0.
  - Column k is read in cycle 1+k and checked in cycle 2+k.
- Inked column found at L:
  - FETCH occurs in cycle L+3.
  - WAIT occurs in cycle L+4.
  - `strip_valid` first goes high in cycle L+5.
- Empty image: `strip_valid` first goes high in cycle COLS+2.
- `busy` is high from cycle 1 through the handshake cycle, and low in the cycle after the handshake.
- `strip_valid` drops in the cycle after the handshake.
- Throughput: at most one result per scan; there is no overlap between scans.

## Test plan
- Leftmost inked column 5; column 35 = 0x...A5 (low byte A5, rest 0); `strip_ready`=1 → `strip_valid` in cycle 10 with `found`=1, `left_col`=5, `strip_col`=35, `strip` low byte 0xA5 and all other bits 0.
- All-zero image → `strip_valid` in cycle 202 with `found`=0, `left_col`=0, `strip_col`=0, `strip`=0. `mem_rd_en` is high for exactly 200 cycles, covering addresses 0..199.
- Leftmost inked column 180 → `strip_col`=199 (clamped) and `strip`=column 199 contents.
- Column 0 inked, column 30 = all ones → `strip_valid` in cycle 5 and `strip` all ones. The speculative read of address 1 in cycle 2 must not affect `strip`.
- Backpressure: `strip_ready` held low for 7 cycles after `strip_valid` rises, with `start` pulsed during OUT → outputs stable for all 7 cycles, `start` is ignored, and `busy` falls the cycle after `strip_ready`=1.
- `rst_n` asserted in cycle 50 of a scan → all outputs return to their reset values asynchronously. A new `start` after release restarts the scan at address 0 with the normal cycle timing.
